// File: rtl/accum_pkg.sv
// accum_pkg: definitions shared by the correlator accumulator readout path.
//
// Contents:
//   NUM_ACC_DEFAULT / ACC_W_DEFAULT  default accumulator count and width
//   TS_W                             width of the optional dump timestamp
//   FRAME_EXTRA                      extra words per frame (timestamp word)
//   readout_state_e                  readout FSM state (idle / sending)
//   frame_len()                      words per frame for a given accumulator count
//
// Build option: ACC_READOUT_TIMESTAMP_EN appends a 16-bit dump timestamp word
// to every frame.

package accum_pkg;

    localparam int unsigned NUM_ACC_DEFAULT = 6;
    localparam int unsigned ACC_W_DEFAULT   = 16;
    localparam int unsigned TS_W            = 16;

`ifdef ACC_READOUT_TIMESTAMP_EN
    localparam int unsigned FRAME_EXTRA = 1;
`else
    localparam int unsigned FRAME_EXTRA = 0;
`endif

    localparam int unsigned FRAME_LEN_DEFAULT = NUM_ACC_DEFAULT + FRAME_EXTRA;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } readout_state_e;

    function automatic int unsigned frame_len(input int unsigned num_acc);
        return num_acc + FRAME_EXTRA;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//
// Ports:
//   clk    in   clock
//   rstn   in   asynchronous active-low reset (count -> 0)
//   clear  in   synchronous clear
//   inc    in   increment request
//   count  out  current count, sticks at all-ones
//
// A clear and an increment in the same cycle load 1, so the event that
// coincides with the clear is not lost.

module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/accum_readout.sv
// accum_readout: drains correlator accumulator dumps onto a valid/ready stream.
//
// On dump_enable while idle, all NUM_ACC accumulator values are captured in one
// cycle and then sent one word per accepted transfer, index 0 first. Dumps that
// arrive while a frame is still draining are dropped and counted in missed_cnt,
// except a dump coinciding with the final transfer, which starts the next frame
// back-to-back.
//
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   dump_enable   in   single-cycle dump strobe
//   accum_bus     in   NUM_ACC*ACC_W accumulator values, word k at [k*ACC_W +: ACC_W]
//   out_valid     out  stream word valid
//   out_ready     in   consumer accepts the word
//   out_data      out  stream word
//   out_index     out  index of the current word
//   out_last      out  final word of the frame
//   missed_cnt    out  saturating count of dropped dumps
//   clear_missed  in   synchronous clear of missed_cnt
//
// Build option: ACC_READOUT_TIMESTAMP_EN adds a free-running 16-bit dump
// counter whose post-increment value is sent as word NUM_ACC of each frame.
// out_index is 3 bits wide, so the frame must fit in 8 words.

module accum_readout
    import accum_pkg::*;
#(
    parameter int unsigned NUM_ACC = NUM_ACC_DEFAULT,
    parameter int unsigned ACC_W   = ACC_W_DEFAULT,
    parameter int unsigned MISS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     dump_enable,
    input  logic [NUM_ACC*ACC_W-1:0] accum_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [2:0]               out_index,
    output logic                     out_last,
    output logic [MISS_W-1:0]        missed_cnt,
    input  logic                     clear_missed
);

    localparam int unsigned FRAME_LEN = frame_len(NUM_ACC);
    localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);

    readout_state_e state_q, state_d;
    logic [2:0]     idx_q, idx_d;

    // Packed so the whole bus loads in one assignment; snap_q[k] is word k.
    logic [NUM_ACC-1:0][ACC_W-1:0] snap_q;

    logic xfer;
    logic last_xfer;
    logic accept;
    logic miss;
    logic [ACC_W-1:0] word_sel;

    assign xfer      = (state_q == StSend) && out_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    // A dump is taken when idle, or when the frame empties in the same cycle.
    assign accept = dump_enable && ((state_q == StIdle) || last_xfer);
    assign miss   = dump_enable && !accept;

    // ------------------------------------------------------------------
    // FSM and word index
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (dump_enable) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = accept ? StSend : StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_q <= '0;
        end else if (accept) begin
            snap_q <= accum_bus;
        end
    end

`ifdef ACC_READOUT_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Dump timestamp: counts every strobe, accepted or not, and the frame
    // carries the value after its own dump has been counted.
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_snap_q;
    logic [TS_W-1:0] ts_next;

    assign ts_next = ts_cnt_q + TS_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt_q  <= '0;
            ts_snap_q <= '0;
        end else begin
            if (dump_enable) begin
                ts_cnt_q <= ts_next;
            end
            if (accept) begin
                ts_snap_q <= ts_next;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output word select
    // ------------------------------------------------------------------
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            if (idx_q == 3'(k)) begin
                word_sel = snap_q[k];
            end
        end
`ifdef ACC_READOUT_TIMESTAMP_EN
        if (idx_q == 3'(NUM_ACC)) begin
            word_sel = ACC_W'(ts_snap_q);
        end
`endif
    end

    assign out_valid = (state_q == StSend);
    assign out_data  = (state_q == StSend) ? word_sel : '0;
    assign out_index = idx_q;
    assign out_last  = (state_q == StSend) && (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Missed-dump counter
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (MISS_W)
    ) u_missed_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear_missed),
        .inc   (miss),
        .count (missed_cnt)
    );

endmodule

// File: tb/tb_accum_readout.sv
module tb_accum_readout;

    localparam int unsigned NUM_ACC  = 6;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned MISS_W   = 8;
    localparam int unsigned BUS_W    = NUM_ACC * ACC_W;
`ifdef ACC_READOUT_TIMESTAMP_EN
    localparam int unsigned F        = NUM_ACC + 1;
`else
    localparam int unsigned F        = NUM_ACC;
`endif
    localparam int unsigned MISS_MAX = (1 << MISS_W) - 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic               dump_enable;
    logic [BUS_W-1:0]   accum_bus;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic [2:0]         out_index;
    logic               out_last;
    logic [MISS_W-1:0]  missed_cnt;
    logic               clear_missed;

    always #5 clk = ~clk;

    accum_readout #(
        .NUM_ACC (NUM_ACC),
        .ACC_W   (ACC_W),
        .MISS_W  (MISS_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .dump_enable  (dump_enable),
        .accum_bus    (accum_bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .missed_cnt   (missed_cnt),
        .clear_missed (clear_missed)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a pending frame as a list of words plus a read position.
    bit               m_busy;
    int               m_pos;
    int               m_missed;
    int               m_ts;
    logic [ACC_W-1:0] m_frame [F];

    logic [ACC_W-1:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] r;
        for (int k = 0; k < NUM_ACC; k++) r[k*ACC_W +: ACC_W] = ACC_W'($urandom);
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] seq_bus(input int base);
        logic [BUS_W-1:0] r;
        for (int k = 0; k < NUM_ACC; k++) r[k*ACC_W +: ACC_W] = ACC_W'(base + k);
        return r;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_pos    = 0;
        m_missed = 0;
        m_ts     = 0;
    endtask

    // One clock of the specified behaviour, applied to the model state.
    task automatic model_step(input bit dump, input logic [BUS_W-1:0] bus,
                              input bit ready, input bit clr);
        bit finishing;
        bit missed;
        finishing = m_busy && ready && (m_pos == F - 1);
        if (dump) m_ts = (m_ts + 1) % 65536;
        missed = dump && m_busy && !finishing;
        if (clr) m_missed = missed ? 1 : 0;
        else if (missed && m_missed < MISS_MAX) m_missed++;
        if (m_busy && ready) begin
            m_pos++;
            if (m_pos == F) begin
                m_busy = 0;
                m_pos  = 0;
            end
        end
        if (dump && !missed) begin
            for (int k = 0; k < NUM_ACC; k++) m_frame[k] = bus[k*ACC_W +: ACC_W];
            if (F > NUM_ACC) m_frame[F-1] = ACC_W'(m_ts);
            m_busy = 1;
            m_pos  = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
        check({tag, ".missed"}, 32'(missed_cnt), 32'(m_missed));
        if (m_busy) begin
            check({tag, ".data"}, 32'(out_data), 32'(m_frame[m_pos]));
            check({tag, ".index"}, 32'(out_index), 32'(m_pos));
            check({tag, ".last"}, 32'(out_last), 32'(m_pos == F - 1));
        end else begin
            check({tag, ".last"}, 32'(out_last), 32'd0);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at next negedge.
    task automatic cycle(input string tag, input bit dump, input logic [BUS_W-1:0] bus,
                         input bit ready, input bit clr);
        dump_enable  = dump;
        accum_bus    = bus;
        out_ready    = ready;
        clear_missed = clr;
        if (out_valid && ready) got.push_back(out_data);
        @(posedge clk);
        model_step(dump, bus, ready, clr);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        dump_enable  = 1'b0;
        accum_bus    = '0;
        out_ready    = 1'b0;
        clear_missed = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit               dump;
        bit               ready;
        bit               exp_valid;
        logic [ACC_W-1:0] exp_data;
        logic [2:0]       exp_index;
        bit               exp_last;
    } vec_t;

    vec_t             tbl [8];
    logic [BUS_W-1:0] bus_a;
    logic [BUS_W-1:0] bus_b;

    initial begin
        // ---------------- reset values ----------------
        do_reset();
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.data", 32'(out_data), 32'd0);
        check("reset.index", 32'(out_index), 32'd0);
        check("reset.last", 32'(out_last), 32'd0);
        check("reset.missed", 32'(missed_cnt), 32'd0);

        // ---------------- directed frame, words 1..6, ready high ----------------
        tbl[0] = '{dump: 1, ready: 0, exp_valid: 1, exp_data: 1, exp_index: 0, exp_last: 0};
        for (int k = 1; k < 6; k++) begin
            tbl[k] = '{dump: 0, ready: 1, exp_valid: 1, exp_data: ACC_W'(k + 1),
                       exp_index: 3'(k), exp_last: (k == 5) && (F == NUM_ACC)};
        end
        if (F > NUM_ACC) begin
            tbl[6] = '{dump: 0, ready: 1, exp_valid: 1, exp_data: 1, exp_index: 6, exp_last: 1};
        end else begin
            tbl[6] = '{dump: 0, ready: 1, exp_valid: 0, exp_data: 0, exp_index: 0, exp_last: 0};
        end
        tbl[7] = '{dump: 0, ready: 1, exp_valid: 0, exp_data: 0, exp_index: 0, exp_last: 0};
        bus_a = seq_bus(1);
        for (int i = 0; i < 8; i++) begin
            dump_enable = tbl[i].dump;
            accum_bus   = bus_a;
            out_ready   = tbl[i].ready;
            @(posedge clk);
            model_step(tbl[i].dump, bus_a, tbl[i].ready, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d.last", i), 32'(out_last), 32'(tbl[i].exp_last));
            check($sformatf("tbl%0d.missed", i), 32'(missed_cnt), 32'd0);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d.data", i), 32'(out_data), 32'(tbl[i].exp_data));
                check($sformatf("tbl%0d.index", i), 32'(out_index), 32'(tbl[i].exp_index));
            end
        end

        // ---------------- ready toggling: hold and in-order delivery ----------------
        do_reset();
        got.delete();
        bus_a = seq_bus(1);
        cycle("tog.dump", 1, bus_a, 0, 0);
        for (int i = 0; i < 2 * F + 2; i++) cycle("tog", 0, '0, (i % 2) == 0, 0);
        check("tog.count", 32'(got.size()), 32'(F));
        for (int k = 0; k < NUM_ACC && k < got.size(); k++) begin
            check($sformatf("tog.word%0d", k), 32'(got[k]), 32'(k + 1));
        end

        // ---------------- three dumps dropped while stalled ----------------
        do_reset();
        bus_a = rand_bus();
        cycle("miss3.dump", 1, bus_a, 0, 0);
        for (int i = 0; i < 3; i++) cycle("miss3.extra", 1, rand_bus(), 0, 0);
        check("miss3.cnt", 32'(missed_cnt), 32'd3);
        check("miss3.word0", 32'(out_data), 32'(bus_a[0 +: ACC_W]));
        for (int i = 0; i < F + 1; i++) cycle("miss3.drain", 0, '0, 1, 0);

        // ---------------- dump exactly on last-word transfer ----------------
        do_reset();
        bus_a = rand_bus();
        bus_b = rand_bus();
        cycle("b2b.dump", 1, bus_a, 0, 0);
        for (int i = 0; i < F - 1; i++) cycle("b2b.run", 0, '0, 1, 0);
        cycle("b2b.last", 1, bus_b, 1, 0);
        check("b2b.valid", 32'(out_valid), 32'd1);
        check("b2b.index", 32'(out_index), 32'd0);
        check("b2b.word0", 32'(out_data), 32'(bus_b[0 +: ACC_W]));
        check("b2b.missed", 32'(missed_cnt), 32'd0);
        for (int i = 0; i < F + 1; i++) cycle("b2b.drain", 0, '0, 1, 0);

        // ---------------- saturation and clear-with-miss ----------------
        do_reset();
        cycle("sat.dump", 1, rand_bus(), 0, 0);
        for (int i = 0; i < 300; i++) cycle("sat.miss", 1, rand_bus(), 0, 0);
        check("sat.cnt", 32'(missed_cnt), 32'd255);
        cycle("sat.clrmiss", 1, rand_bus(), 0, 1);
        check("sat.clrmiss_cnt", 32'(missed_cnt), 32'd1);
        cycle("sat.clr", 0, '0, 0, 1);
        check("sat.clr_cnt", 32'(missed_cnt), 32'd0);

`ifdef ACC_READOUT_TIMESTAMP_EN
        // ---------------- timestamps 1 and 3 with a miss between ----------------
        do_reset();
        cycle("ts.dump1", 1, rand_bus(), 0, 0);
        cycle("ts.miss", 1, rand_bus(), 0, 0);
        for (int i = 0; i < NUM_ACC; i++) cycle("ts.run1", 0, '0, 1, 0);
        check("ts.idx1", 32'(out_index), 32'd6);
        check("ts.val1", 32'(out_data), 32'd1);
        cycle("ts.end1", 0, '0, 1, 0);
        cycle("ts.dump2", 1, rand_bus(), 0, 0);
        for (int i = 0; i < NUM_ACC; i++) cycle("ts.run2", 0, '0, 1, 0);
        check("ts.idx2", 32'(out_index), 32'd6);
        check("ts.val2", 32'(out_data), 32'd3);
        cycle("ts.end2", 0, '0, 1, 0);
`endif

        // ---------------- reset mid-frame ----------------
        do_reset();
        cycle("rst.dump", 1, rand_bus(), 0, 0);
        cycle("rst.miss", 1, rand_bus(), 0, 0);
        cycle("rst.w0", 0, '0, 1, 0);
        cycle("rst.w1", 0, '0, 1, 0);
        check("rst.at_word2", 32'(out_index), 32'd2);
        rstn = 1'b0;
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.index", 32'(out_index), 32'd0);
        check("rst.last", 32'(out_last), 32'd0);
        check("rst.missed", 32'(missed_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rst.after", 0, '0, 1, 0);

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle("rand", $urandom_range(0, 5) == 0, rand_bus(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accum_readout.md
# accum_readout

Drains correlator accumulator dumps to the tracking-loop side of the channel. Each time the channel asserts `dump_enable`, the block snapshots all NUM_ACC accumulator outputs in one cycle. It then serialises the snapshot word-by-word over a valid/ready stream to the bus/FIFO interface. Dumps that arrive while a snapshot is still being drained are counted as missed.

## Interface
- `NUM_ACC`, default 6: accumulators per channel (I/Q × early/prompt/late).
- `ACC_W`, default 16: accumulator width; matches the accumulator output.
- `MISS_W`, default 8: width of the missed-dump counter.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `dump_enable`  in  1  single-cycle dump strobe, the same strobe that drives the accumulators.
- `accum_bus`  in  NUM_ACC*ACC_W  accumulator values; index k is at bits [k*ACC_W +: ACC_W]. Valid in the `dump_enable` cycle.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  ACC_W  stream word.
- `out_index`  out  3  index of the current word.
- `out_last`  out  1  final word of the frame.
- `missed_cnt`  out  MISS_W  saturating count of dropped dumps.
- `clear_missed`  in  1  synchronous clear of `missed_cnt`.

## Operation
- States: IDLE, SEND.
- IDLE + `dump_enable`:
  - Latch `accum_bus` into the snapshot register.
  - Set index to 0 and enter SEND.
- SEND:
  - `out_valid`=1; `out_data` = snapshot[index].
  - A word transfers when `out_valid`&`out_ready`; the index then increments.
  - Transfer of the last word returns the block to IDLE.
- `out_data`, `out_index` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- `dump_enable` in SEND, not on the last-word transfer cycle:
  - The dump is dropped.
  - `missed_cnt` increments, saturating at 2^MISS_W-1.
- `dump_enable` on the last-word transfer cycle:
  - The dump is accepted: the snapshot is reloaded, index goes to 0, and the block stays in SEND.
  - `missed_cnt` is unchanged.
- `clear_missed` together with a miss in the same cycle: `missed_cnt`=1.
- `out_index` width is fixed at 3, which supports NUM_ACC+1 ≤ 8.

## Timing
- Reset values: state IDLE; `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `missed_cnt`=0; snapshot=0.
- Latency: `dump_enable` in cycle N → `out_valid`=1 with word 0 in cycle N+1.
- With `out_ready` held high, one word transfers per cycle. A frame of F words occupies cycles N+1..N+F.
- `rstn` asserted mid-frame aborts the frame immediately. The partial frame is not resumed and does not count as a miss.
- `out_valid` never deasserts without a completed transfer, except on reset.

## Configuration
- `ACC_READOUT_TIMESTAMP_EN` defined:
  - A free-running 16-bit dump counter increments on every `dump_enable`, whether accepted or missed, and wraps at 0xFFFF→0.
  - Its value after the increment is latched with each accepted snapshot.
  - The latched value is sent as an extra word at index NUM_ACC, so frame length F = NUM_ACC+1 and `out_last` is on that word.
- Undefined: F = NUM_ACC, no counter logic, and `out_last` is on index NUM_ACC-1.

## Structure
- Shared package `accum_pkg`: `ACC_W`/`NUM_ACC` defaults, the readout state enum (IDLE, SEND), and the frame-length constant derived from the macro.
- One sub-module, `sat_counter`: a parameterised saturating up-counter with synchronous clear, used for `missed_cnt`.
- Snapshot, index and FSM live in the top-level block.

## Test plan
- Reset, then one dump with accum_bus words 0x0001..0x0006 and `out_ready`=1:
  - words 1..6 appear on cycles N+1..N+6 with `out_index` 0..5;
  - `out_last` is high only at index 5;
  - `missed_cnt`=0.
- Same dump with `out_ready` toggling 1,0,1,0…: each word is held stable until accepted, and all 6 words arrive in order with no duplicates.
- `out_ready`=0, and three extra dumps during SEND: `missed_cnt`=3, and the snapshot still holds the first dump's values.
- Dump strobed exactly on the last-word transfer: a new frame starts next cycle with the new values, and `missed_cnt` is unchanged.
- 300 missed dumps with MISS_W=8 → `missed_cnt`=255. Then `clear_missed` together with a miss → `missed_cnt`=1.
- With `ACC_READOUT_TIMESTAMP_EN`: two accepted dumps plus one missed between them → frame timestamps 1 then 3, each at index 6. Also, `rstn` pulsed low at word 2 → `out_valid`=0 immediately and all outputs return to reset values.
